// File: rtl/timer_bank_if.sv
// timer_bank_if: control, compare-write and status signals of the timer bank
interface timer_bank_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH = 32
);
   localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   logic [CHANNELS-1:0] ch_en, ch_clr, ch_mode, irq_clr, alarm, irq_flag;
   logic cmp_wr, irq;
   logic [SEL_W-1:0] cmp_sel;
   logic [WIDTH-1:0] cmp_data;
   logic [CHANNELS*WIDTH-1:0] value;
   modport master (
      output ch_en, ch_clr, ch_mode, cmp_wr, cmp_sel, cmp_data, irq_clr,
      input value, alarm, irq_flag, irq
   );
   modport slave (
      input ch_en, ch_clr, ch_mode, cmp_wr, cmp_sel, cmp_data, irq_clr,
      output value, alarm, irq_flag, irq
   );
endinterface

// File: rtl/timer_bank.sv
// timer_bank: prescaled multi-channel timers with compare alarms
// define TIMER_BANK_IRQ_EN to build sticky irq flags with write-one-to-clear
module timer_bank #(
   parameter int CHANNELS = 4,
   parameter int WIDTH = 32,
   parameter int PRESCALE = 100000,
   parameter int PRESC_W = 17
) (
   input logic clk,
   input logic n_rst,
   timer_bank_if.slave bus
);
   localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   logic [PRESC_W-1:0] presc;
   logic tick;
   logic [CHANNELS-1:0] match, alarm_d, alarm_q;
   assign tick = presc == PRESC_W'(PRESCALE - 1);
   assign alarm_d = match & bus.ch_en & ~bus.ch_clr & {CHANNELS{tick}};
   always_ff @(posedge clk) begin
      presc <= (n_rst || tick) ? '0 : presc + 1'b1;
      alarm_q <= n_rst ? '0 : alarm_d;
   end
   assign bus.alarm = alarm_q;
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] cnt, cmp;
      // match looks at the pre-update value and the pre-write compare
      assign match[i] = cnt == cmp;
      always_ff @(posedge clk) begin
         if (n_rst) begin
            cnt <= '0;
            cmp <= '1;
         end else begin
            cnt <= bus.ch_clr[i] ? '0 : !(tick && bus.ch_en[i]) ? cnt : (match[i] && bus.ch_mode[i]) ? '0 : cnt + 1'b1;
            if (bus.cmp_wr && bus.cmp_sel == SEL_W'(i)) cmp <= bus.cmp_data;
         end
      end
      assign bus.value[i*WIDTH +: WIDTH] = cnt;
   end
`ifdef TIMER_BANK_IRQ_EN
   logic [CHANNELS-1:0] flag, flag_d;
   logic irq_q;
   assign flag_d = alarm_d | (flag & ~bus.irq_clr);
   always_ff @(posedge clk) begin
      flag <= n_rst ? '0 : flag_d;
      irq_q <= n_rst ? 1'b0 : |flag_d;
   end
   assign bus.irq_flag = flag;
   assign bus.irq = irq_q;
`else
   logic unused_irq_clr;
   assign unused_irq_clr = ^bus.irq_clr;
   assign bus.irq_flag = '0;
   assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: randomized and directed checks of timer_bank against a cycle-count model
module tb_timer_bank;
   localparam int CH = 2, W = 8, PS = 10, PW = 4;
`ifdef TIMER_BANK_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif
   logic clk = 1'b0;
   logic n_rst = 1'b1;
   int n_checks = 0;
   int n_fail = 0;
   int m_cyc;
   int m_val [CH];
   int m_cmp [CH];
   bit m_al [CH];
   bit m_fl [CH];
   always #5 clk = ~clk;
   timer_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
   timer_bank #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PS), .PRESC_W(PW)) dut (
      .clk(clk),
      .n_rst(n_rst),
      .bus(bus)
   );
   function automatic logic [CH*W-1:0] exp_value();
      logic [CH*W-1:0] r;
      for (int c = 0; c < CH; c++) r[c*W +: W] = W'(m_val[c]);
      return r;
   endfunction
   function automatic logic [CH-1:0] exp_alarm();
      logic [CH-1:0] r;
      for (int c = 0; c < CH; c++) r[c] = m_al[c];
      return r;
   endfunction
   function automatic logic [CH-1:0] exp_flag();
      logic [CH-1:0] r;
      for (int c = 0; c < CH; c++) r[c] = m_fl[c];
      return r;
   endfunction
   function automatic bit tick_next();
      return (m_cyc % PS) == PS - 1;
   endfunction
   // one clock edge of the model: a tick falls on every PS-th cycle since reset
   task automatic step();
      bit tk, rst, wr;
      int sel, data;
      int nv [CH];
      bit na [CH];
      logic [CH-1:0] en, clr, mode, iclr;
      tk = tick_next();
      rst = n_rst; en = bus.ch_en; clr = bus.ch_clr; mode = bus.ch_mode; iclr = bus.irq_clr;
      wr = bus.cmp_wr; sel = int'(bus.cmp_sel); data = int'(bus.cmp_data);
      for (int c = 0; c < CH; c++) begin
         nv[c] = m_val[c];
         na[c] = 1'b0;
         if (clr[c]) nv[c] = 0;
         else if (tk && en[c]) begin
            na[c] = m_val[c] == m_cmp[c];
            nv[c] = (na[c] && mode[c]) ? 0 : (m_val[c] + 1) % (1 << W);
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         m_cyc = 0;
         for (int c = 0; c < CH; c++) begin
            m_val[c] = 0; m_cmp[c] = (1 << W) - 1; m_al[c] = 0; m_fl[c] = 0;
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            m_fl[c] = IRQ && (na[c] || (m_fl[c] && !iclr[c]));
            m_val[c] = nv[c];
            m_al[c] = na[c];
         end
         if (wr && sel < CH) m_cmp[sel] = data;
         m_cyc++;
      end
   endtask
   task automatic write_cmp(input int sel, input int data);
      bus.cmp_wr = 1'b1; bus.cmp_sel = 1'(sel); bus.cmp_data = W'(data);
      step();
      bus.cmp_wr = 1'b0;
   endtask
   task automatic test_reset();
      bus.ch_en = '0; bus.ch_clr = '0; bus.ch_mode = '0; bus.irq_clr = '0;
      bus.cmp_wr = 1'b0; bus.cmp_sel = '0; bus.cmp_data = '0;
      n_rst = 1'b1;
      step(); step();
      n_checks++; if (bus.value !== '0) begin n_fail++; $display("FAIL reset value: got %h want 0", bus.value); end
      n_checks++; if (bus.alarm !== '0) begin n_fail++; $display("FAIL reset alarm: got %b want 0", bus.alarm); end
      n_checks++; if (bus.irq_flag !== '0 || bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset irq: got %b/%b want 0/0", bus.irq_flag, bus.irq); end
      n_rst = 1'b0;
   endtask
   task automatic test_count();
      bus.ch_en = 2'b01; bus.ch_mode = 2'b00;
      for (int k = 1; k <= 20; k++) begin
         step();
         n_checks++;
         if (bus.value !== exp_value() || bus.alarm !== exp_alarm()) begin
            n_fail++; $display("FAIL count k=%0d: value %h alarm %b want %h %b", k, bus.value, bus.alarm, exp_value(), exp_alarm());
         end
         if (k == 10 || k == 20) begin
            n_checks++; if (bus.value[7:0] !== 8'(k / 10)) begin n_fail++; $display("FAIL count edge%0d: value0 %0d want %0d", k, bus.value[7:0], k / 10); end
         end
      end
      n_checks++; if (bus.value[15:8] !== 8'd0 || bus.alarm !== 2'b00) begin n_fail++; $display("FAIL count idle: value1 %0d alarm %b want 0 00", bus.value[15:8], bus.alarm); end
   endtask
   task automatic test_reload();
      int pulses = 0, last = -1, spacing_bad = 0, exp_pulses = 0;
      bus.ch_clr = 2'b01;
      write_cmp(0, 3);
      bus.ch_clr = 2'b00; bus.ch_mode = 2'b01; bus.ch_en = 2'b01;
      for (int k = 0; k < 100; k++) begin
         step();
         n_checks++;
         if (bus.value !== exp_value() || bus.alarm !== exp_alarm()) begin
            n_fail++; $display("FAIL reload k=%0d: value %h alarm %b want %h %b", k, bus.value, bus.alarm, exp_value(), exp_alarm());
         end
         if (m_al[0]) exp_pulses++;
         if (bus.alarm[0] === 1'b1) begin
            if (last >= 0 && k - last != 40) spacing_bad++;
            last = k; pulses++;
         end
      end
      n_checks++; if (pulses != exp_pulses || pulses < 2 || spacing_bad != 0) begin n_fail++; $display("FAIL reload pulses: got %0d (bad spacing %0d) want %0d every 40", pulses, spacing_bad, exp_pulses); end
   endtask
   task automatic test_clr_on_tick();
      int k = 0;
      bus.ch_mode = 2'b00; bus.ch_clr = 2'b01;
      write_cmp(0, 200);
      bus.ch_clr = 2'b00;
      while (!(m_val[0] == 5 && tick_next()) && k < 200) begin step(); k++; end
      n_checks++; if (k >= 200) begin n_fail++; $display("FAIL clr setup: timeout value0 %0d want 5", m_val[0]); end
      bus.ch_clr = 2'b01;
      step();
      bus.ch_clr = 2'b00;
      n_checks++; if (bus.value[7:0] !== 8'd0 || bus.alarm[0] !== 1'b0) begin n_fail++; $display("FAIL clr tick: value0 %0d alarm0 %b want 0 0", bus.value[7:0], bus.alarm[0]); end
   endtask
   task automatic test_wrap();
      int k = 0, extra = 0;
      bus.ch_mode = 2'b00; bus.ch_clr = 2'b01;
      write_cmp(0, 255);
      bus.ch_clr = 2'b00;
      while (!(m_val[0] == 255 && tick_next()) && k < 3000) begin step(); k++; end
      n_checks++; if (k >= 3000 || bus.value[7:0] !== 8'd255) begin n_fail++; $display("FAIL wrap setup: value0 %0d want 255", bus.value[7:0]); end
      step();
      n_checks++; if (bus.value[7:0] !== 8'd0 || bus.alarm[0] !== 1'b1) begin n_fail++; $display("FAIL wrap match: value0 %0d alarm0 %b want 0 1", bus.value[7:0], bus.alarm[0]); end
      for (int j = 0; j < 30; j++) begin
         step();
         if (bus.alarm[0] !== 1'b0) extra++;
      end
      n_checks++; if (extra != 0 || bus.value !== exp_value()) begin n_fail++; $display("FAIL wrap after: extra alarms %0d value %h want 0 %h", extra, bus.value, exp_value()); end
   endtask
   task automatic test_irq();
      int k = 0;
      bus.ch_en = 2'b00; bus.ch_clr = 2'b11; bus.irq_clr = 2'b11;
      write_cmp(1, 2);
      bus.ch_clr = 2'b00; bus.irq_clr = 2'b00; bus.ch_mode = 2'b10; bus.ch_en = 2'b10;
      while (!m_al[1] && k < 100) begin step(); k++; end
      n_checks++; if (k >= 100 || bus.alarm[1] !== 1'b1) begin n_fail++; $display("FAIL irq first match: alarm1 %b want 1", bus.alarm[1]); end
      n_checks++; if (bus.irq_flag[1] !== IRQ || bus.irq !== IRQ) begin n_fail++; $display("FAIL irq set: flag1 %b irq %b want %b %b", bus.irq_flag[1], bus.irq, IRQ, IRQ); end
      k = 0;
      while (!(tick_next() && m_val[1] == m_cmp[1]) && k < 100) begin step(); k++; end
      bus.irq_clr = 2'b10;
      step();
      bus.irq_clr = 2'b00;
      n_checks++; if (bus.irq_flag[1] !== IRQ || bus.alarm[1] !== 1'b1) begin n_fail++; $display("FAIL irq set wins: flag1 %b alarm1 %b want %b 1", bus.irq_flag[1], bus.alarm[1], IRQ); end
      step(); step(); step();
      bus.irq_clr = 2'b11;
      step();
      bus.irq_clr = 2'b00;
      n_checks++; if (bus.irq_flag !== 2'b00 || bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq clear: flag %b irq %b want 00 0", bus.irq_flag, bus.irq); end
   endtask
   task automatic test_reset_mid();
      int k = 0;
      bus.ch_en = 2'b01; bus.ch_mode = 2'b00; bus.ch_clr = 2'b11;
      write_cmp(0, 200);
      bus.ch_clr = 2'b00;
      while (!(m_val[0] == 4 && m_cyc % PS == 7) && k < 200) begin step(); k++; end
      n_checks++; if (k >= 200 || bus.value[7:0] !== 8'd4) begin n_fail++; $display("FAIL rstmid setup: value0 %0d want 4", bus.value[7:0]); end
      n_rst = 1'b1;
      step();
      n_rst = 1'b0;
      n_checks++; if (bus.value !== '0 || bus.alarm !== '0 || bus.irq_flag !== '0 || bus.irq !== 1'b0) begin n_fail++; $display("FAIL rstmid outputs: value %h alarm %b flag %b irq %b want 0", bus.value, bus.alarm, bus.irq_flag, bus.irq); end
      n_checks++; if (dut.g_ch[0].cmp !== 8'hff || dut.g_ch[1].cmp !== 8'hff) begin n_fail++; $display("FAIL rstmid cmp: %h %h want ff ff", dut.g_ch[0].cmp, dut.g_ch[1].cmp); end
      k = 0;
      while (bus.value[7:0] === 8'd0 && k < 30) begin step(); k++; end
      n_checks++; if (k != 10) begin n_fail++; $display("FAIL rstmid tick latency: %0d edges want 10", k); end
   endtask
   task automatic test_random();
      int bad = 0;
      for (int k = 0; k < 600; k++) begin
         bus.ch_en = 2'($urandom_range(0, 3) != 0 ? 3 : $urandom_range(0, 3));
         bus.ch_clr = $urandom_range(0, 15) == 0 ? 2'($urandom) : 2'b00;
         if ($urandom_range(0, 31) == 0) bus.ch_mode = 2'($urandom);
         bus.cmp_wr = $urandom_range(0, 7) == 0;
         bus.cmp_sel = 1'($urandom);
         bus.cmp_data = 8'($urandom_range(0, 6));
         bus.irq_clr = $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b00;
         n_rst = $urandom_range(0, 199) == 0;
         step();
         n_checks++;
         if (bus.value !== exp_value() || bus.alarm !== exp_alarm() || bus.irq_flag !== exp_flag() || bus.irq !== |exp_flag()) begin
            n_fail++; bad++;
            if (bad < 10) $display("FAIL random k=%0d: value %h alarm %b flag %b irq %b want %h %b %b %b", k, bus.value, bus.alarm, bus.irq_flag, bus.irq, exp_value(), exp_alarm(), exp_flag(), |exp_flag());
         end
      end
      n_rst = 1'b0; bus.cmp_wr = 1'b0; bus.ch_clr = '0; bus.irq_clr = '0;
   endtask
   initial begin
      test_reset();
      test_count();
      test_reload();
      test_clr_on_tick();
      test_wrap();
      test_irq();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
